// File: rtl/set_mode_ctrl_pkg.sv
// set_mode_ctrl_pkg
//   Shared definitions for the set-mode controller and the clock/alarm setters:
//   mode state encoding, set-select codes, default timing parameters and the
//   cyclic mode-advance helper.
package set_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL   = 3'd0,
    ST_CLK_HOUR = 3'd1,
    ST_CLK_MIN  = 3'd2,
    ST_ALM_HOUR = 3'd3,
    ST_ALM_MIN  = 3'd4
  } mode_state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HOUR = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;

  localparam int DEF_DEBOUNCE_MS     = 20;
  localparam int DEF_TIMEOUT_MS      = 10000;
  localparam int DEF_CONFIRM_HOLD_MS = 1100;

  // One step of the mode cycle NORMAL -> CLK_HOUR -> CLK_MIN -> ALM_HOUR -> ALM_MIN -> NORMAL.
  function automatic mode_state_e next_mode(input mode_state_e s);
    case (s)
      ST_NORMAL:   return ST_CLK_HOUR;
      ST_CLK_HOUR: return ST_CLK_MIN;
      ST_CLK_MIN:  return ST_ALM_HOUR;
      ST_ALM_HOUR: return ST_ALM_MIN;
      default:     return ST_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Two-flop synchronizer, tick-sampled debounce counter and press pulse for
//   one raw push button.
//   Ports:
//     i_clk    system clock
//     i_rst    synchronous active-high reset
//     i_tick   1 kHz sampling strobe (one i_clk cycle wide)
//     i_key    raw asynchronous key, active-high
//     o_press  one-cycle pulse, high in the cycle whose closing edge takes the
//              debounced level from 0 to 1; release produces nothing
module key_debounce
  import set_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_key,
  output logic o_press
);

  // Counter only has to hold DEBOUNCE_MS-1; it restarts instead of reaching DEBOUNCE_MS.
  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = (r_sync2 != r_level);
  // The DEBOUNCE_MS-th consecutive differing sample flips the level.
  assign w_accept = i_tick && w_differ && (r_cnt == CNT_LAST);
  assign o_press  = w_accept && !r_level;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl
//   Two-button set-mode controller for the clock: the mode key steps through
//   clock hour/minute and alarm hour/minute setting, the confirm key raises a
//   timed confirm level for the setters, and an idle timeout returns to NORMAL.
//   Ports:
//     clk_50m           system clock (only clock)
//     cr                synchronous active-high reset
//     tick_1k           one-cycle 1 kHz enable strobe
//     key_mode          raw mode button, active-high
//     key_confirm       raw confirm button, active-high
//     clock_set_select  00 none, 01 clock hour, 10 clock minute
//     alarm_set_select  00 none, 01 alarm hour, 10 alarm minute
//     confirm           adjust/confirm level to the setters
//     set_active        high in any state other than NORMAL
module set_mode_ctrl
  import set_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int TIMEOUT_MS      = DEF_TIMEOUT_MS,
  parameter int CONFIRM_HOLD_MS = DEF_CONFIRM_HOLD_MS
) (
  input  logic       clk_50m,
  input  logic       cr,
  input  logic       tick_1k,
  input  logic       key_mode,
  input  logic       key_confirm,
  output logic [1:0] clock_set_select,
  output logic [1:0] alarm_set_select,
  output logic       confirm,
  output logic       set_active
);

  localparam int HOLD_W = $clog2(CONFIRM_HOLD_MS + 1);
  localparam int TO_W   = $clog2(TIMEOUT_MS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(CONFIRM_HOLD_MS);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_MS);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_MS - 1);

  mode_state_e       r_state;
  mode_state_e       w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [TO_W-1:0]   r_to;
  logic [TO_W-1:0]   w_to_nxt;
  logic              w_mode_press;
  logic              w_conf_press;
  logic              w_timeout;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_dbc_mode (
    .i_clk   (clk_50m),
    .i_rst   (cr),
    .i_tick  (tick_1k),
    .i_key   (key_mode),
    .o_press (w_mode_press)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_dbc_conf (
    .i_clk   (clk_50m),
    .i_rst   (cr),
    .i_tick  (tick_1k),
    .i_key   (key_confirm),
    .o_press (w_conf_press)
  );

  // Fires on the tick that would take the idle count to TIMEOUT_MS.
  assign w_timeout = tick_1k && (r_state != ST_NORMAL) && (r_to == TO_LAST);

  always_ff @(posedge clk_50m) begin
    if (cr) begin
      r_state <= ST_NORMAL;
      r_hold  <= '0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_to    <= w_to_nxt;
    end
  end

  // Priority: mode press, then timeout, then confirm/tick bookkeeping.
  // A mode press swallows a coincident confirm press and a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_to_nxt    = r_to;
    if (w_mode_press) begin
      w_state_nxt = next_mode(r_state);
      w_hold_nxt  = '0;
      w_to_nxt    = '0;
    end else if (w_timeout) begin
      w_state_nxt = ST_NORMAL;
      w_hold_nxt  = '0;
      w_to_nxt    = '0;
    end else begin
      // Reload wins over a same-cycle decrement, so a re-press never leaves a gap.
      if (w_conf_press && (r_state != ST_NORMAL)) begin
        w_hold_nxt = HOLD_LOAD;
      end else if (tick_1k && (r_hold != '0)) begin
        w_hold_nxt = r_hold - HOLD_W'(1);
      end
      if ((r_state == ST_NORMAL) || w_conf_press) begin
        w_to_nxt = '0;
      end else if (tick_1k && (r_to != TO_MAX)) begin
        w_to_nxt = r_to + TO_W'(1);
      end
    end
  end

  always_comb begin
    clock_set_select = SEL_NONE;
    alarm_set_select = SEL_NONE;
    case (r_state)
      ST_CLK_HOUR: clock_set_select = SEL_HOUR;
      ST_CLK_MIN:  clock_set_select = SEL_MIN;
      ST_ALM_HOUR: alarm_set_select = SEL_HOUR;
      ST_ALM_MIN:  alarm_set_select = SEL_MIN;
      default:     ;
    endcase
  end

  assign confirm    = (r_hold != '0);
  assign set_active = (r_state != ST_NORMAL);

endmodule
